ro_count_spi_serializer: RTL

Downstream stage of the SPI clock-count sequencer in the all-digital V/T sensor. It watches the sequencer's measurement enable (ENOUT) to detect when the ring-oscillator (RO) window closes. It then captures the frozen RO count and shifts a framed word (header, status, count, parity) out on SPI MISO within the same SPI_CS-low transaction. It runs on SPI_Clk and is cleared by the same gated reset as the sequencer.

---
 rtl/sensor_pkg.sv | 19 +
 rtl/ro_win_timer.sv | 27 ++
 rtl/ro_count_spi_serializer.sv | 118 +++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the V/T sensor SPI readout path: frame header,
// serializer state encoding and frame length helper.
package sensor_pkg;

    localparam logic [3:0] FRAME_HDR = 4'b1010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } ser_state_e;

    // Header (4) + overflow + timeout + count + parity
    function automatic int frame_len(input int cnt_w);
        return cnt_w + 7;
    endfunction

endpackage

// File: rtl/ro_win_timer.sv
// Saturating 8-bit counter of SPI_Clk falling edges during which the RO
// window was open; flags when the forced-capture limit has been reached.
module ro_win_timer #(
    parameter logic [7:0] MAX_WIN = 8'd252
) (
    input  logic       SPI_Clk,
    input  logic       SPICNT_RST,
    input  logic       start,
    input  logic       count_en,
    output logic [7:0] Win_Len,
    output logic       timeout
);

    always_ff @(negedge SPI_Clk or negedge SPICNT_RST) begin
        if (!SPICNT_RST) begin
            Win_Len <= 8'd0;
        end else if (start) begin
            Win_Len <= 8'd1;
        end else if (count_en && (Win_Len < MAX_WIN)) begin
            Win_Len <= Win_Len + 8'd1;
        end
    end

    // Level, not edge: the FSM qualifies it with a high ENOUT sample
    assign timeout = (Win_Len == MAX_WIN);

endmodule

// File: rtl/ro_count_spi_serializer.sv
// Captures the frozen RO count when the measurement window closes and shifts
// {header, ovf, timeout, count, parity} out on MISO, MSB first, once per CS.
module ro_count_spi_serializer
    import sensor_pkg::*;
#(
    parameter int         CNT_W   = 16,
    parameter logic [7:0] MAX_WIN = 8'd252
) (
    input  logic             SPI_Clk,
    input  logic             SPICNT_RST,
    input  logic             ENOUT,
    input  logic [CNT_W-1:0] RO_Cnt,
    input  logic             RO_Ovf,
    output logic             SPI_MISO,
    output logic             SPI_MISO_OE,
    output logic             Shift_Done,
    output logic [7:0]       Win_Len
);

    localparam int FL   = frame_len(CNT_W);
    localparam int BC_W = $clog2(FL);

    ser_state_e      state_q, state_d;
    logic [FL-1:0]   shreg;
    logic [BC_W-1:0] bit_cnt;
    logic [FL-1:0]   frame_word;
    logic            start, count_en, timeout;
    logic            capture, to_flag, shift, finish;

    ro_win_timer #(.MAX_WIN(MAX_WIN)) u_win_timer (
        .SPI_Clk    (SPI_Clk),
        .SPICNT_RST (SPICNT_RST),
        .start      (start),
        .count_en   (count_en),
        .Win_Len    (Win_Len),
        .timeout    (timeout)
    );

    always_ff @(negedge SPI_Clk or negedge SPICNT_RST) begin
        if (!SPICNT_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        count_en = 1'b0;
        capture  = 1'b0;
        to_flag  = 1'b0;
        shift    = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ENOUT) begin
                    start   = 1'b1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!ENOUT) begin
                    capture = 1'b1;
                    state_d = SHIFT;
                end else if (timeout) begin
                    capture = 1'b1;
                    to_flag = 1'b1;
                    state_d = SHIFT;
                end else begin
                    count_en = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Even parity over the payload, header excluded
    assign frame_word = {FRAME_HDR, RO_Ovf, to_flag, RO_Cnt, ^{RO_Ovf, to_flag, RO_Cnt}};

    always_ff @(negedge SPI_Clk or negedge SPICNT_RST) begin
        if (!SPICNT_RST) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            Shift_Done  <= 1'b0;
        end else if (capture) begin
            shreg       <= frame_word;
            bit_cnt     <= BC_W'(FL - 1);
            SPI_MISO    <= frame_word[FL-1];
            SPI_MISO_OE <= 1'b1;
        end else if (shift) begin
            shreg    <= {shreg[FL-2:0], 1'b0};
            bit_cnt  <= bit_cnt - 1'b1;
            SPI_MISO <= shreg[FL-2];
        end else if (finish) begin
            shreg       <= '0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            Shift_Done  <= 1'b1;
        end
    end

endmodule
